// File: rtl/score_bcd_encoder.sv
// score_bcd_encoder: iterative binary-to-BCD converter (shift-add-3).
// Turns a binary score into four packed BCD digits for the seven-segment
// scanner. One bit of the score is folded in per SHIFT cycle, and the packed
// result is published only in DONE, so nums never shows a partial value.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits above the units digit are replaced by
//   4'hF, which the scanner shows as a dark digit. The units digit always
//   shows. Timing and handshake are the same in both builds.
module score_bcd_encoder #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [15:0]      nums,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  // The counter only has to count up to BIN_W-1 SHIFT cycles.
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  // The saturation limit at the input width, so the compare is unsigned.
  localparam logic [BIN_W-1:0] MAX_V    = BIN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [BIN_W-1:0]   sh_q;
  logic [15:0]        acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [15:0]        nums_q;
  logic               busy_q;
  logic               done_q;
  logic               overflow_q;

  logic [BIN_W-1:0]   binSat;
  logic               binOver;
  logic [15:0]        accAdj;
  logic [16+BIN_W-1:0] shiftVal;
  logic [15:0]        acc_d;
  logic [BIN_W-1:0]   sh_d;
  logic [15:0]        nums_d;

`ifdef LEADING_ZERO_BLANK_EN
  // Blanks zero digits from the thousands down to the tens and stops at the
  // first non-zero digit, so interior zeros (as in 1002) stay visible.
  function automatic logic [15:0] blankLeading(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[15:12] == 4'd0) begin
      r[15:12] = 4'hF;
      if (v[11:8] == 4'd0) begin
        r[11:8] = 4'hF;
        if (v[7:4] == 4'd0) begin
          r[7:4] = 4'hF;
        end
      end
    end
    return r;
  endfunction
`endif

  // Clamp the incoming score to the largest value four digits can show.
  always_comb begin
    binOver = (bin > MAX_V);
    binSat  = binOver ? MAX_V : bin;
  end

  // One double-dabble step: digits of 5 or more get +3 so that the following
  // left shift carries into the next digit, then the score MSB enters bit 0.
  always_comb begin
    accAdj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[i*4 +: 4] >= 4'd5) begin
        accAdj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
      end
    end
    shiftVal = {accAdj, sh_q} << 1;
    acc_d    = shiftVal[16+BIN_W-1:BIN_W];
    sh_d     = shiftVal[BIN_W-1:0];
  end

  // The value published to the scanner when a conversion completes.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    nums_d = blankLeading(acc_q);
`else
    nums_d = acc_q;
`endif
  end

  // Conversion FSM with registered outputs. Reset drops any conversion in
  // flight, and start is ignored outside IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      nums_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sh_q       <= binSat;
            overflow_q <= binOver;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          nums_q  <= nums_d;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign nums     = nums_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: doc/score_bcd_encoder.md
Name: score_bcd_encoder

Overview:
Iterative binary-to-BCD converter (shift-add-3 / double dabble). It produces the 16-bit packed 4-digit BCD word that the seven-segment scanner consumes on its nums input. Game logic supplies a binary score with a start pulse. The block returns four BCD digits, a one-cycle done strobe, and a saturation flag. The nums output is held stable between conversions, so the scanner never sees partial values.

Parameters:
BIN_W, 14, width of binary input; 14 bits covers 0..16383.
MAX_VAL, 9999, saturation limit; inputs above this are clamped to it before conversion.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start  input  1  request conversion of bin; sampled only in IDLE
bin  input  BIN_W  binary value to convert; captured on accepted start
nums  output  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle strobe; nums updated in the same cycle
overflow  output  1  high if the last accepted bin exceeded MAX_VAL; held until the next accepted start

Behaviour:
- Reset (async, rst=1): state=IDLE; nums=16'h0000; busy=0; done=0; overflow=0; internal shift/accumulator/counter cleared. Applies immediately, including mid-conversion. Any in-flight result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1: sh <= (bin>MAX_VAL) ? MAX_VAL : bin; overflow <= (bin>MAX_VAL); acc <= 0; cnt <= 0; go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT: busy=1. Each cycle:
  - For each of the 4 acc digits, add 3 if digit>=5, computed combinationally on the current acc.
  - Then shift {acc,sh} left by 1; MSB of sh enters acc bit 0.
  - cnt increments. After exactly BIN_W SHIFT cycles, go to DONE.
- DONE: nums <= final acc; done=1 for this single cycle; busy=0; go to IDLE next cycle.
- Latency: start sampled at edge N; done high and nums valid from edge N+BIN_W+1 (N+15 at default). Throughput: one conversion per BIN_W+2 cycles.
- start while in SHIFT or DONE is ignored; no queuing. bin is don't-care except at the accepted start edge.
- nums changes only in DONE (or on reset). overflow changes only on an accepted start (or on reset).
- Width rules:
  - acc is 16 bits. Saturation guarantees every digit stays <=9 and no carry is lost.
  - Comparison against MAX_VAL is unsigned at BIN_W width.
- done and busy are never high simultaneously.

Optional Feature:
Macro: LEADING_ZERO_BLANK_EN.
- Defined: at DONE, each leading zero digit above units, scanning thousands→tens, is replaced with 4'hF, which the scanner decodes as all segments off. The units digit is never blanked, so 0 → 16'hFFF0 and 42 → 16'hFF42. Interior zeros are kept: 1002 → 16'h1002.
- Undefined: nums is plain packed BCD with zeros shown.
- Timing and handshake are identical in both builds.

Test Plan:
1. Reset, then start=1 for one cycle with bin=1234 → busy high for 14 cycles; done=1 exactly at edge N+15 with nums=16'h1234; overflow=0.
2. bin=0, then bin=9999, then bin=59 (exercises the add-3 boundary), back-to-back on earliest accepted start → nums=16'h0000, 16'h9999, 16'h0059. With LEADING_ZERO_BLANK_EN: 16'hFFF0, 16'h9999, 16'hFF59.
3. bin=12000 → nums=16'h9999, overflow=1. Next conversion of bin=7 → overflow returns 0 at its start edge; nums=16'h0007.
4. start held high continuously with bin changing each cycle → only values sampled at IDLE edges are converted; pulses during SHIFT/DONE are ignored; one done per BIN_W+2 cycles.
5. Assert rst asynchronously mid-SHIFT, between clock edges, after a prior result of 16'h0321 → nums, busy, done, overflow go to 0 immediately, before the next edge; no done follows. A new start after release converts normally.
